// File: rtl/scariv_clint_if.sv
// Interrupt levels from the core-local interruptor to the hart's
// CSR/interrupt logic.
interface scariv_clint_if;
  logic ipi_valid;
  logic time_irq_valid;

  modport master (
    output ipi_valid,
    output time_irq_valid
  );

  modport slave (
    input ipi_valid,
    input time_irq_valid
  );
endinterface

// File: rtl/scariv_clint.sv
// scariv_clint: core-local interruptor for one hart.
// Holds msip / mtimecmp / mtime behind a one-outstanding request/response
// register port. It also produces registered software- and timer-interrupt
// levels.
module scariv_clint #(
  parameter int unsigned  TICK_DIV  = 1,
  parameter logic [63:0]  BASE_ADDR = 64'h0000_0000_0200_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,

  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_cmd,
  input  logic [63:0] i_req_addr,
  input  logic [63:0] i_req_data,
  input  logic [7:0]  i_req_byte_en,

  output logic        o_resp_valid,
  output logic [63:0] o_resp_data,
  output logic        o_resp_error,
  input  logic        i_resp_ready,

  scariv_clint_if.master clint_if
);

  localparam logic [15:0] OFF_MSIP     = 16'h0000;
  localparam logic [15:0] OFF_MTIMECMP = 16'h4000;
  localparam logic [15:0] OFF_MTIME    = 16'hBFF8;
  localparam logic [7:0]  TICK_MAX     = 8'(TICK_DIV - 32'd1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  // Byte-enable merge: byte k of the result comes from wdata when be[k].
  function automatic logic [63:0] merge_bytes(
    input logic [63:0] old_val,
    input logic [63:0] wdata,
    input logic [7:0]  be
  );
    logic [63:0] res;
    res = old_val;
    for (int k = 0; k < 8; k++) begin
      if (be[k]) begin
        res[k*8 +: 8] = wdata[k*8 +: 8];
      end else begin
        res[k*8 +: 8] = old_val[k*8 +: 8];
      end
    end
    return res;
  endfunction

  state_e      state_r;
  state_e      state_next_s;
  logic        req_ready_s;
  logic        accept_s;

  logic        msip_r;
  logic [63:0] mtimecmp_r;
  logic [63:0] mtime_r;
  logic [7:0]  tick_cnt_r;
  logic        tick_s;

  logic        ipi_r;
  logic        time_irq_r;

  logic [63:0] resp_data_r;
  logic        resp_error_r;

  logic [15:0] offset_s;
  logic        aligned_s;
  logic        sel_msip_s;
  logic        sel_mtimecmp_s;
  logic        sel_mtime_s;
  logic        addr_error_s;
  logic [63:0] rd_data_s;
  logic        wr_msip_s;
  logic        wr_mtimecmp_s;
  logic        wr_mtime_s;

  // Only the low 16 address bits are decoded; the region base is not checked.
  logic        unused_s;
  assign unused_s = ^{i_req_addr[63:16], BASE_ADDR};

  // Address decode, read mux and write strobes for the accepted request.
  always_comb begin
    offset_s       = i_req_addr[15:0];
    aligned_s      = (i_req_addr[2:0] == 3'b000);
    sel_msip_s     = aligned_s && (offset_s == OFF_MSIP);
    sel_mtimecmp_s = aligned_s && (offset_s == OFF_MTIMECMP);
    sel_mtime_s    = aligned_s && (offset_s == OFF_MTIME);
    addr_error_s   = !(sel_msip_s || sel_mtimecmp_s || sel_mtime_s);
    rd_data_s      = 64'h0;
    if (sel_msip_s) begin
      rd_data_s = {63'h0, msip_r};
    end else if (sel_mtimecmp_s) begin
      rd_data_s = mtimecmp_r;
    end else if (sel_mtime_s) begin
      rd_data_s = mtime_r;
    end else begin
      rd_data_s = 64'h0;
    end
    wr_msip_s     = accept_s && i_req_cmd && sel_msip_s;
    wr_mtimecmp_s = accept_s && i_req_cmd && sel_mtimecmp_s;
    wr_mtime_s    = accept_s && i_req_cmd && sel_mtime_s;
  end

  // Request/response FSM: next state and request-ready.
  always_comb begin
    state_next_s = state_r;
    req_ready_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        req_ready_s = 1'b1;
        if (i_req_valid) begin
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RESP: begin
        req_ready_s = i_resp_ready;
        if (i_resp_ready && i_req_valid) begin
          state_next_s = ST_RESP;
        end else if (i_resp_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        req_ready_s  = 1'b0;
      end
    endcase
  end

  assign accept_s    = i_req_valid && req_ready_s;
  assign o_req_ready = req_ready_s;
  assign tick_s      = (tick_cnt_r == TICK_MAX);

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Response payload: latched on acceptance, cleared once consumed.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      resp_data_r  <= 64'h0;
      resp_error_r <= 1'b0;
    end else if (accept_s) begin
      resp_data_r  <= i_req_cmd ? 64'h0 : rd_data_s;
      resp_error_r <= addr_error_s;
    end else if ((state_r == ST_RESP) && i_resp_ready) begin
      resp_data_r  <= 64'h0;
      resp_error_r <= 1'b0;
    end else begin
      resp_data_r  <= resp_data_r;
      resp_error_r <= resp_error_r;
    end
  end

  // Software-interrupt pending bit; only bit 0 of byte 0 is writable.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      msip_r <= 1'b0;
    end else if (wr_msip_s && i_req_byte_en[0]) begin
      msip_r <= i_req_data[0];
    end else begin
      msip_r <= msip_r;
    end
  end

  // Timer compare register with byte-enable merge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (wr_mtimecmp_s) begin
      mtimecmp_r <= merge_bytes(mtimecmp_r, i_req_data, i_req_byte_en);
    end else begin
      mtimecmp_r <= mtimecmp_r;
    end
  end

  // Prescaler; a write to mtime restarts the tick period.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tick_cnt_r <= 8'h00;
    end else if (wr_mtime_s || tick_s) begin
      tick_cnt_r <= 8'h00;
    end else begin
      tick_cnt_r <= tick_cnt_r + 8'h01;
    end
  end

  // Free-running time; a write wins over a coincident tick.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mtime_r <= 64'h0;
    end else if (wr_mtime_s) begin
      mtime_r <= merge_bytes(mtime_r, i_req_data, i_req_byte_en);
    end else if (tick_s) begin
      mtime_r <= mtime_r + 64'h1;
    end else begin
      mtime_r <= mtime_r;
    end
  end

  // Registered interrupt levels, derived from the committed register values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ipi_r      <= 1'b0;
      time_irq_r <= 1'b0;
    end else begin
      ipi_r      <= msip_r;
      time_irq_r <= (mtime_r >= mtimecmp_r);
    end
  end

  assign o_resp_valid            = (state_r == ST_RESP);
  assign o_resp_data             = resp_data_r;
  assign o_resp_error            = resp_error_r;
  assign clint_if.ipi_valid      = ipi_r;
  assign clint_if.time_irq_valid = time_irq_r;

endmodule

// File: tb/tb_scariv_clint.sv
// Self-checking bench for scariv_clint. Two instances (TICK_DIV=1 and 4)
// receive identical stimulus. A time-based reference model predicts every
// response and interrupt level.
module tb_scariv_clint;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_cmd = 1'b0;
  logic [63:0] req_addr = 64'h0;
  logic [63:0] req_data = 64'h0;
  logic [7:0]  req_be = 8'h00;
  logic        resp_ready = 1'b1;

  logic        rdy [2];
  logic        rv  [2];
  logic [63:0] rd  [2];
  logic        re  [2];
  logic        ipi [2];
  logic        tirq[2];

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  scariv_clint_if if_a ();
  scariv_clint_if if_b ();

  scariv_clint #(.TICK_DIV(1)) u_dut1 (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req_valid(req_valid), .o_req_ready(rdy[0]), .i_req_cmd(req_cmd),
    .i_req_addr(req_addr), .i_req_data(req_data), .i_req_byte_en(req_be),
    .o_resp_valid(rv[0]), .o_resp_data(rd[0]), .o_resp_error(re[0]),
    .i_resp_ready(resp_ready), .clint_if(if_a)
  );

  scariv_clint #(.TICK_DIV(4)) u_dut4 (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req_valid(req_valid), .o_req_ready(rdy[1]), .i_req_cmd(req_cmd),
    .i_req_addr(req_addr), .i_req_data(req_data), .i_req_byte_en(req_be),
    .o_resp_valid(rv[1]), .o_resp_data(rd[1]), .o_resp_error(re[1]),
    .i_resp_ready(resp_ready), .clint_if(if_b)
  );

  assign ipi[0]  = if_a.ipi_valid;
  assign tirq[0] = if_a.time_irq_valid;
  assign ipi[1]  = if_b.ipi_valid;
  assign tirq[1] = if_b.time_irq_valid;

  always #5 i_clk = ~i_clk;

  // ---------------- reference model ----------------
  // mtime is a function of elapsed edges since the last write (or reset):
  // value after edge c = base + (c - base_cycle) / div.
  int          cyc = 0;
  int          m_bcyc = 0;
  logic [63:0] m_base [2];
  logic [63:0] m_cmp;
  logic        m_msip;
  logic        m_pend;
  logic [63:0] m_rdata [2];
  logic        m_rerr;
  int          div_of [2] = '{1, 4};

  function automatic logic [63:0] mtime_at(input int k, input int c);
    logic [63:0] n;
    n = 64'(longint'((c - m_bcyc) / div_of[k]));
    return m_base[k] + n;
  endfunction

  function automatic logic [63:0] be_merge(input logic [63:0] old_v,
                                           input logic [63:0] new_v,
                                           input logic [7:0] be);
    logic [63:0] mask;
    mask = 64'h0;
    for (int b = 0; b < 8; b++) if (be[b]) mask = mask | (64'hFF << (8 * b));
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  task automatic model_reset();
    m_bcyc = cyc;
    m_base[0] = 64'h0;
    m_base[1] = 64'h0;
    m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
    m_msip = 1'b0;
    m_pend = 1'b0;
    m_rerr = 1'b0;
    m_rdata[0] = 64'h0;
    m_rdata[1] = 64'h0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock edge with the currently driven inputs, predicting
  // the effect in the model and comparing both instances afterwards.
  task automatic step();
    logic        acc;
    logic [63:0] cur [2];
    logic        n_ipi;
    logic        n_tirq [2];
    logic        al;
    logic [15:0] off;
    acc = req_valid && (!m_pend || resp_ready);
    for (int k = 0; k < 2; k++) begin
      cur[k] = mtime_at(k, cyc);
      n_tirq[k] = (cur[k] >= m_cmp);
    end
    n_ipi = m_msip;
    if (acc) begin
      off = req_addr[15:0];
      al = (req_addr[2:0] == 3'b000);
      m_rdata[0] = 64'h0;
      m_rdata[1] = 64'h0;
      m_rerr = 1'b0;
      if (al && off == 16'h0000) begin
        if (req_cmd) begin
          if (req_be[0]) m_msip = req_data[0];
        end else begin
          m_rdata[0] = {63'h0, m_msip};
          m_rdata[1] = {63'h0, m_msip};
        end
      end else if (al && off == 16'h4000) begin
        if (req_cmd) m_cmp = be_merge(m_cmp, req_data, req_be);
        else begin
          m_rdata[0] = m_cmp;
          m_rdata[1] = m_cmp;
        end
      end else if (al && off == 16'hBFF8) begin
        if (req_cmd) begin
          for (int k = 0; k < 2; k++) m_base[k] = be_merge(cur[k], req_data, req_be);
          m_bcyc = cyc + 1;
        end else begin
          m_rdata[0] = cur[0];
          m_rdata[1] = cur[1];
        end
      end else begin
        m_rerr = 1'b1;
      end
    end
    m_pend = acc || (m_pend && !resp_ready);
    @(posedge i_clk);
    cyc++;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("req_ready[%0d]", k), {63'h0, rdy[k]}, {63'h0, (!m_pend || resp_ready)});
      chk($sformatf("resp_valid[%0d]", k), {63'h0, rv[k]}, {63'h0, m_pend});
      if (m_pend) begin
        chk($sformatf("resp_data[%0d]", k), rd[k], m_rdata[k]);
        chk($sformatf("resp_error[%0d]", k), {63'h0, re[k]}, {63'h0, m_rerr});
      end
      chk($sformatf("ipi_valid[%0d]", k), {63'h0, ipi[k]}, {63'h0, n_ipi});
      chk($sformatf("time_irq[%0d]", k), {63'h0, tirq[k]}, {63'h0, n_tirq[k]});
    end
  endtask

  task automatic req(input logic cmd, input logic [63:0] addr,
                     input logic [63:0] data, input logic [7:0] be);
    req_valid = 1'b1;
    req_cmd = cmd;
    req_addr = addr;
    req_data = data;
    req_be = be;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apply_reset();
    req_valid = 1'b0;
    i_reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_resp_valid[%0d]", k), {63'h0, rv[k]}, 64'h0);
      chk($sformatf("rst_ipi[%0d]", k), {63'h0, ipi[k]}, 64'h0);
      chk($sformatf("rst_time_irq[%0d]", k), {63'h0, tirq[k]}, 64'h0);
      chk($sformatf("rst_req_ready[%0d]", k), {63'h0, rdy[k]}, 64'h1);
    end
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    model_reset();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        cmd;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{1'b0, 64'h0200_4000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    tbl[1]  = '{1'b0, 64'h0200_0000, 64'h0, 8'h00, 64'h0, 1'b0};
    tbl[2]  = '{1'b1, 64'h0200_0000, 64'h1, 8'h01, 64'h0, 1'b0};
    tbl[3]  = '{1'b0, 64'h0200_0000, 64'h0, 8'h00, 64'h1, 1'b0};
    tbl[4]  = '{1'b1, 64'h0200_0000, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 64'h0, 1'b0};
    tbl[5]  = '{1'b0, 64'h0200_0000, 64'h0, 8'h00, 64'h0, 1'b0};
    tbl[6]  = '{1'b0, 64'h0200_0008, 64'h0, 8'h00, 64'h0, 1'b1};
    tbl[7]  = '{1'b0, 64'h0200_4004, 64'h0, 8'h00, 64'h0, 1'b1};
    tbl[8]  = '{1'b1, 64'h0200_4004, 64'h5, 8'hFF, 64'h0, 1'b1};
    tbl[9]  = '{1'b0, 64'h0200_4000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    tbl[10] = '{1'b1, 64'h0200_4000, 64'h1234_5678_9ABC_DEF0, 8'h0F, 64'h0, 1'b0};
    tbl[11] = '{1'b0, 64'h0200_4000, 64'h0, 8'h00, 64'hFFFF_FFFF_9ABC_DEF0, 1'b0};
    tbl[12] = '{1'b1, 64'hABCD_0000, 64'h1, 8'h01, 64'h0, 1'b0};
    tbl[13] = '{1'b0, 64'h0000_0000, 64'h0, 8'h00, 64'h1, 1'b0};
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] ra;
    model_reset();
    #2;
    apply_reset();

    // Back-to-back table of register accesses.
    resp_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      req(tbl[i].cmd, tbl[i].addr, tbl[i].data, tbl[i].be);
      step();
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("tbl%0d_data[%0d]", i, k), rd[k], tbl[i].exp_data);
        chk($sformatf("tbl%0d_err[%0d]", i, k), {63'h0, re[k]}, {63'h0, tbl[i].exp_err});
      end
    end
    // msip back to 0, then consecutive mtime reads.
    req(1'b1, 64'h0, 64'h0, 8'h01); step();
    idle(3);
    for (int i = 0; i < 4; i++) begin req(1'b0, 64'hBFF8, 64'h0, 8'h00); step(); end
    idle(2);

    // mtime wrap: FFFF..FE read 9 edges later gives 6 (div 1) and 0 (div 4).
    req(1'b1, 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF); step();
    idle(8);
    req(1'b0, 64'hBFF8, 64'h0, 8'h00); step();
    chk("wrap_div1", rd[0], 64'h6);
    chk("wrap_div4", rd[1], 64'h0);
    // Partial write changes only the low word.
    req(1'b1, 64'hBFF8, 64'h1111_2222_3333_4444, 8'h0F); step();
    req(1'b0, 64'hBFF8, 64'h0, 8'h00); step();
    idle(2);

    // Timer interrupt: mtime=100, mtimecmp=105, then raise mtimecmp.
    req(1'b1, 64'hBFF8, 64'd100, 8'hFF); step();
    req(1'b1, 64'h4000, 64'd105, 8'hFF); step();
    idle(8);
    chk("tirq_div1_set", {63'h0, tirq[0]}, 64'h1);
    req(1'b1, 64'h4000, 64'd1000, 8'hFF); step();
    idle(2);
    chk("tirq_div1_clr", {63'h0, tirq[0]}, 64'h0);

    // Backpressure: response held for 5 cycles with pending requests.
    req(1'b0, 64'h4000, 64'h0, 8'h00); step();
    resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin req(1'b0, 64'hBFF8, 64'h0, 8'h00); step(); end
    chk("hold_data", rd[0], 64'd1000);
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin req(1'b0, (i % 2 == 0) ? 64'hBFF8 : 64'h4000, 64'h0, 8'h00); step(); end
    idle(1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: ra = 64'h0000;
        1: ra = 64'h4000;
        2: ra = 64'hBFF8;
        3: ra = 64'h0008;
        4: ra = 64'h4004;
        default: ra = {$urandom, $urandom};
      endcase
      req_valid = ($urandom_range(0, 3) != 0);
      req_cmd = $urandom_range(0, 1) == 1;
      req_addr = ra;
      req_data = {$urandom, $urandom};
      if (ra[15:0] == 16'hBFF8 || ra[15:0] == 16'h4000) req_data = {56'h0, 8'($urandom_range(0, 200))};
      req_be = 8'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    resp_ready = 1'b1;
    idle(2);

    // Reset while a response is pending.
    resp_ready = 1'b0;
    req(1'b0, 64'h4000, 64'h0, 8'h00); step();
    apply_reset();
    resp_ready = 1'b1;
    req(1'b0, 64'hBFF8, 64'h0, 8'h00); step();
    chk("post_reset_mtime1", rd[0], 64'h0);
    chk("post_reset_mtime4", rd[1], 64'h0);
    req(1'b0, 64'h4000, 64'h0, 8'h00); step();
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
